// File: rtl/gray_counter_ctrl_if.sv
// Control/LED bundle for the Gray counter controller.
// The master drives the controls; the slave drives leds/tick/wrap.
interface gray_counter_ctrl_if #(
  parameter int N = 4
);
  logic         en;
  logic         dir;
  logic         mode;
  logic [1:0]   speed;
  logic         clr;
  logic [N-1:0] leds;
  logic         tick;
  logic         wrap;

  modport master (
    output en, dir, mode, speed, clr,
    input  leds, tick, wrap
  );

  modport slave (
    input  en, dir, mode, speed, clr,
    output leds, tick, wrap
  );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Programmable-rate up/down counter with Gray or binary LED output.
// The prescaler fires a step every div cycles; leds/tick/wrap update on that edge.
module gray_counter_ctrl #(
  parameter int N        = 4,
  parameter int DISTANCE = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  gray_counter_ctrl_if.slave bus
);

  localparam int          CW   = $clog2(DISTANCE + 1);
  localparam logic [31:0] DIST = 32'(DISTANCE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  bin_q, bin_d;
  logic [N-1:0]  leds_q, leds_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [31:0]   div;
  logic [CW-1:0] lim;
  logic          step;
  logic          roll;

  // A shift that underflows to zero still needs a 1-cycle period.
  always_comb begin
    div = DIST >> bus.speed;
    if (div == 32'd0) begin
      div = 32'd1;
    end
    lim = CW'(div - 32'd1);
  end

  // >= lets a shrinking divisor fire on the next edge.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (!bus.en) begin
      cnt_d = cnt_q;
    end else if (cnt_q >= lim) begin
      cnt_d = '0;
      step  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    roll  = bus.dir ? (bin_q == '1) : (bin_q == '0);
    bin_d = bin_q;
    if (step) begin
      bin_d = bus.dir ? bin_q + N'(1)
                      : bin_q - N'(1);
    end
    if (bus.clr) begin
      bin_d = '0;
    end
    leds_d = bus.mode ? (bin_d ^ (bin_d >> 1))
                      : bin_d;
    tick_d = step;
    wrap_d = step & roll;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bin_q  <= '0;
      leds_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      leds_q <= leds_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Bench for gray_counter_ctrl: cycle model plus directed scenarios.
// N=3, DISTANCE=8 throughout.
module tb_gray_counter_ctrl;

  localparam int N = 3;
  localparam int D = 8;
  localparam int M = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  gray_counter_ctrl_if #(.N(N)) bus ();

  gray_counter_ctrl #(
    .N(N),
    .DISTANCE(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase counter and counter value as plain integers.
  int         m_cnt;
  int         m_val;
  logic [2:0] m_leds;
  logic       m_tick;
  logic       m_wrap;

  always @(posedge clk or posedge rst) begin : model
    int d;
    bit st;
    int nv;
    if (rst) begin
      m_cnt  <= 0;
      m_val  <= 0;
      m_leds <= '0;
      m_tick <= 1'b0;
      m_wrap <= 1'b0;
    end else begin
      d = D >> bus.speed;
      if (d < 1) d = 1;
      st = 1'b0;
      nv = m_val;
      if (bus.clr) begin
        m_cnt <= 0;
        nv = 0;
      end else if (bus.en) begin
        if (m_cnt >= d - 1) begin
          m_cnt <= 0;
          st = 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (st) nv = bus.dir ? (m_val + 1) % M
                           : (m_val + M - 1) % M;
      m_val  <= nv;
      m_tick <= st;
      m_wrap <= st && ((bus.dir && m_val == M - 1)
                   || (!bus.dir && m_val == 0));
      m_leds <= bus.mode ? 3'(nv ^ (nv >> 1)) : 3'(nv);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("model_leds", 32'(bus.leds), 32'(m_leds));
      chk("model_tick", 32'(bus.tick), 32'(m_tick));
      chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    end
  end

  task automatic steps(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (bus.tick !== 1'b1 && n < 64);
    if (bus.tick !== 1'b1) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_reset(input logic e, input logic d,
                          input logic m, input logic [1:0] s);
    @(negedge clk);
    rst = 1'b1;
    bus.en = e;
    bus.dir = d;
    bus.mode = m;
    bus.speed = s;
    bus.clr = 1'b0;
    #1;
    chk("rst_leds", 32'(bus.leds), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] g_seq [8];
  logic [2:0] b_seq [3];
  logic [2:0] lv;
  int n;

  initial begin
    g_seq = '{3'd1, 3'd3, 3'd2, 3'd6,
              3'd7, 3'd5, 3'd4, 3'd0};
    b_seq = '{3'd7, 3'd6, 3'd5};
    bus.en = 1'b0;
    bus.dir = 1'b1;
    bus.mode = 1'b1;
    bus.speed = 2'd0;
    bus.clr = 1'b0;
    #1 rst = 1'b1;

    // Gray up-count, full cycle
    do_reset(1'b1, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      chk("s1_period", n, 8);
      chk("s1_leds", 32'(bus.leds), 32'(g_seq[i]));
      chk("s1_wrap", 32'(bus.wrap), (i == 7) ? 1 : 0);
    end

    // Binary down-count
    do_reset(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      chk("s2_period", n, 8);
      chk("s2_leds", 32'(bus.leds), 32'(b_seq[i]));
      chk("s2_wrap", 32'(bus.wrap), (i == 0) ? 1 : 0);
    end

    // Speed settings
    for (int s = 1; s < 4; s++) begin
      do_reset(1'b1, 1'b1, 1'b1, 2'(s));
      wait_tick(n);
      chk("s3_first", n, 8 >> s);
      wait_tick(n);
      chk("s3_period", n, 8 >> s);
    end

    // Speed 0 -> 2 at cnt=5
    do_reset(1'b1, 1'b1, 1'b0, 2'd0);
    steps(5);
    bus.speed = 2'd2;
    wait_tick(n);
    chk("s3_switch", n, 1);
    wait_tick(n);
    chk("s3_after", n, 2);

    // Pause at cnt=3 for 20 cycles
    do_reset(1'b1, 1'b1, 1'b1, 2'd0);
    wait_tick(n);
    steps(3);
    bus.en = 1'b0;
    lv = bus.leds;
    chk("s4_leds0", 32'(lv), 1);
    for (int i = 0; i < 20; i++) begin
      steps(1);
      chk("s4_tick", 32'(bus.tick), 0);
      chk("s4_frozen", 32'(bus.leds), 32'(lv));
    end
    bus.en = 1'b1;
    wait_tick(n);
    chk("s4_resume", n, 5);

    // clr on a scheduled tick edge
    do_reset(1'b1, 1'b1, 1'b1, 2'd0);
    wait_tick(n);
    steps(7);
    bus.clr = 1'b1;
    steps(1);
    chk("s5_tick", 32'(bus.tick), 0);
    chk("s5_leds", 32'(bus.leds), 0);
    chk("s5_wrap", 32'(bus.wrap), 0);
    bus.clr = 1'b0;
    wait_tick(n);
    chk("s5_period", n, 8);
    chk("s5_leds1", 32'(bus.leds), 1);

    // Async reset at bin=5
    do_reset(1'b1, 1'b1, 1'b0, 2'd3);
    steps(5);
    chk("s6_leds5", 32'(bus.leds), 5);
    chk("s6_tick1", 32'(bus.tick), 1);
    #1 rst = 1'b1;
    #1;
    chk("s6_async_leds", 32'(bus.leds), 0);
    chk("s6_async_tick", 32'(bus.tick), 0);
    chk("s6_async_wrap", 32'(bus.wrap), 0);

    // Mode toggle while paused
    do_reset(1'b1, 1'b1, 1'b0, 2'd3);
    steps(5);
    bus.en = 1'b0;
    bus.mode = 1'b1;
    steps(1);
    chk("s6_gray", 32'(bus.leds), 7);
    bus.mode = 1'b0;
    steps(1);
    chk("s6_bin", 32'(bus.leds), 5);
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
